// File: rtl/wb_scratch_pkg.sv
// Shared types and constants for the Wishbone scratch-RAM slave.
// Holds the FSM encoding, address-decode width, doorbell address and range-check helper.
package wb_scratch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    HOLD
  } wb_state_e;

  localparam int WB_DECODE_W = 24;
  localparam logic [WB_DECODE_W-1:0] DOORBELL_ADR = '0;

  // Any decoded bit above the RAM index makes the access out of range.
  function automatic logic adr_out_of_range(input logic [WB_DECODE_W-1:0] adr,
                                            input int addr_w);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < WB_DECODE_W; i++) begin
      if (i >= addr_w && adr[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/wb_scratch_if.sv
// Wishbone classic-cycle slave bus bundle between a master and the scratch RAM.
// Master drives request fields; slave returns data, acknowledge and the doorbell level.
interface wb_scratch_if;

  logic        wbs_we_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_int_o;

  modport master (
    output wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_int_o
  );

  modport slave (
    input  wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_int_o
  );

endinterface

// File: rtl/wb_scratch_ram.sv
// Single-port 2^ADDR_W x 32 RAM, per-byte write enables, registered read (block-RAM style).
// One cycle read latency; rdata holds its value until the next read-enabled cycle.
module wb_scratch_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (we == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_scratch_slave.sv
// Wishbone classic scratch RAM slave: ACK WAIT_STATES+1 cycles after strobe, no stalls beyond that.
// Optional doorbell interrupt on word 0 when WB_SCRATCH_INT_EN is defined; otherwise wbs_int_o is 0.
module wb_scratch_slave
  import wb_scratch_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic         clk,
  input  logic         rst,
  wb_scratch_if.slave  wbs
);

  localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_state_e         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] adr_q;
  logic              oor_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [31:0]       dat_q;

  logic              req;
  logic              take;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_rdata;
  logic              commit_wr;
  logic              unused_adr_hi;

  assign req  = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign take = (state_q == IDLE) && req;

  assign unused_adr_hi = ^wbs.wbs_adr_i[31:WB_DECODE_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = 4'd0;
    case (state_q)
      IDLE: begin
        if (req) state_d = (WAIT_STATES == 0) ? ACK : WAIT;
      end
      WAIT: begin
        // Dropping cyc abandons the transfer before anything is committed.
        if (!wbs.wbs_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == WS_LAST) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ACK: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (!wbs.wbs_stb_i || !wbs.wbs_cyc_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      oor_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'b0000;
      dat_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        adr_q <= wbs.wbs_adr_i[ADDR_W-1:0];
        oor_q <= adr_out_of_range(wbs.wbs_adr_i[WB_DECODE_W-1:0], ADDR_W);
        we_q  <= wbs.wbs_we_i;
        sel_q <= wbs.wbs_sel_i;
        dat_q <= wbs.wbs_dat_i;
      end
    end
  end

  // Reads launch on the accepting edge straight from the bus address; writes
  // commit on the ACK edge from the latched copy, so the port never collides.
  assign commit_wr = (state_q == ACK) && we_q && !oor_q;
  assign ram_en    = take || commit_wr;
  assign ram_we    = commit_wr ? sel_q : 4'b0000;
  assign ram_addr  = (state_q == ACK) ? adr_q : wbs.wbs_adr_i[ADDR_W-1:0];

  wb_scratch_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (dat_q),
    .rdata (ram_rdata)
  );

  assign wbs.wbs_ack_o = (state_q == ACK);
  assign wbs.wbs_dat_o = ((state_q == ACK) && !we_q && !oor_q) ? ram_rdata : 32'h0;

`ifdef WB_SCRATCH_INT_EN
  logic int_q;
  logic bell_hit;

  assign bell_hit = (state_q == ACK) && !oor_q && (adr_q == DOORBELL_ADR[ADDR_W-1:0]);

  // Set is checked first so it wins over a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_q <= 1'b0;
    end else if (bell_hit && we_q) begin
      int_q <= 1'b1;
    end else if (bell_hit && !we_q) begin
      int_q <= 1'b0;
    end
  end

  assign wbs.wbs_int_o = int_q;
`else
  assign wbs.wbs_int_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_scratch_slave.sv
// Self-checking bench for wb_scratch_slave (ADDR_W=8, WAIT_STATES=2).
// Expected read data is queued when a transfer is issued and popped when its ACK arrives.
`timescale 1ns/1ps
module tb_wb_scratch_slave;
  import wb_scratch_pkg::*;

  localparam int ADDR_W = 8;
  localparam int WS     = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_scratch_if bus ();

  wb_scratch_slave #(
    .ADDR_W      (ADDR_W),
    .WAIT_STATES (WS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wbs (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int cycle = 0;
  always @(posedge clk) cycle++;

  // Results of the most recent wb_do call.
  logic [31:0] rd;
  int          lat;
  bit          ok;
  logic        ack_after, irq_ack, irq_after;
  int          ack_cyc;

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
  endtask

  task automatic wb_do(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    ok = 1'b0; lat = 0; rd = 32'hx; irq_ack = 1'bx; ack_cyc = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (bus.wbs_ack_o === 1'b1) begin
        ok = 1'b1; rd = bus.wbs_dat_o; irq_ack = bus.wbs_int_o; ack_cyc = cycle;
      end
    end
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    ack_after = bus.wbs_ack_o;
    irq_after = bus.wbs_int_o;
  endtask

  task automatic test_reset();
    bus_idle();
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.wbs_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", bus.wbs_ack_o); end
    checks++; if (bus.wbs_int_o !== 1'b0) begin errors++; $display("FAIL reset_int got %b want 0", bus.wbs_int_o); end
    checks++; if (bus.wbs_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h want 0", bus.wbs_dat_o); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_write_read();
    logic [31:0] e;
    wb_do(1'b1, 32'd5, 32'hDEADBEEF, 4'hF);
    checks++; if (!ok) begin errors++; $display("FAIL wr5_ack got none want ack"); end
    checks++; if (lat != WS + 1) begin errors++; $display("FAIL wr5_latency got %0d want %0d", lat, WS + 1); end
    checks++; if (ack_after !== 1'b0) begin errors++; $display("FAIL wr5_ack_pulse got %b want 0", ack_after); end
    exp_q.push_back(32'hDEADBEEF);
    wb_do(1'b0, 32'd5, 32'h0, 4'hF);
    e = exp_q.pop_front();
    checks++; if (!ok || rd !== e) begin errors++; $display("FAIL rd5 got %h want %h", rd, e); end
    checks++; if (lat != WS + 1) begin errors++; $display("FAIL rd5_latency got %0d want %0d", lat, WS + 1); end
  endtask

  task automatic test_byte_sel();
    logic [31:0] e;
    wb_do(1'b1, 32'd7, 32'h11223344, 4'hF);
    wb_do(1'b1, 32'd7, 32'hAABBCCDD, 4'b0101);
    exp_q.push_back(32'h11BB33DD);
    wb_do(1'b0, 32'd7, 32'h0, 4'hF);
    e = exp_q.pop_front();
    checks++; if (!ok || rd !== e) begin errors++; $display("FAIL bytesel_0101 got %h want %h", rd, e); end
    wb_do(1'b1, 32'd7, 32'hFFFFFFFF, 4'b1000);
    exp_q.push_back(32'hFFBB33DD);
    wb_do(1'b0, 32'd7, 32'h0, 4'hF);
    e = exp_q.pop_front();
    checks++; if (!ok || rd !== e) begin errors++; $display("FAIL bytesel_1000 got %h want %h", rd, e); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] e;
    wb_do(1'b1, 32'd0, 32'h600D0000, 4'hF);
    exp_q.push_back(32'h0);
    wb_do(1'b0, 32'h00000100, 32'h0, 4'hF);
    e = exp_q.pop_front();
    checks++; if (!ok || rd !== e) begin errors++; $display("FAIL oor_rd_100 got %h want %h", rd, e); end
    checks++; if (lat != WS + 1) begin errors++; $display("FAIL oor_latency got %0d want %0d", lat, WS + 1); end
    exp_q.push_back(32'h0);
    wb_do(1'b0, 32'h00800000, 32'h0, 4'hF);
    e = exp_q.pop_front();
    checks++; if (!ok || rd !== e) begin errors++; $display("FAIL oor_rd_bit23 got %h want %h", rd, e); end
    wb_do(1'b1, 32'h00000100, 32'hBAD0BAD0, 4'hF);
    checks++; if (!ok) begin errors++; $display("FAIL oor_wr_ack got none want ack"); end
    exp_q.push_back(32'h600D0000);
    wb_do(1'b0, 32'd0, 32'h0, 4'hF);
    e = exp_q.pop_front();
    checks++; if (!ok || rd !== e) begin errors++; $display("FAIL oor_wr_discard got %h want %h", rd, e); end
    // Bits above the decoded range are ignored.
    exp_q.push_back(32'hDEADBEEF);
    wb_do(1'b0, 32'hFF000005, 32'h0, 4'hF);
    e = exp_q.pop_front();
    checks++; if (!ok || rd !== e) begin errors++; $display("FAIL upper_bits_ignored got %h want %h", rd, e); end
  endtask

  task automatic test_abort();
    logic [31:0] e;
    int acks;
    wb_do(1'b1, 32'd3, 32'h00000055, 4'hF);
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = 32'd3; bus.wbs_dat_i = 32'h1; bus.wbs_sel_i = 4'hF;
    @(posedge clk); #1;
    bus_idle();
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o === 1'b1) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL abort_no_ack got %0d acks want 0", acks); end
    exp_q.push_back(32'h00000055);
    wb_do(1'b0, 32'd3, 32'h0, 4'hF);
    e = exp_q.pop_front();
    checks++; if (!ok || rd !== e) begin errors++; $display("FAIL abort_no_commit got %h want %h", rd, e); end
  endtask

  task automatic test_long_strobe();
    logic [31:0] e;
    int acks;
    bit got;
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = 32'd30; bus.wbs_dat_i = 32'hCAFE0001; bus.wbs_sel_i = 4'hF;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o === 1'b1) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL long_stb_first_ack got none want ack"); end
    bus.wbs_dat_i = 32'hCAFE0002;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o === 1'b1) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL long_stb_extra_ack got %0d want 0", acks); end
    @(posedge clk); #1;
    bus_idle();
    exp_q.push_back(32'hCAFE0001);
    wb_do(1'b0, 32'd30, 32'h0, 4'hF);
    e = exp_q.pop_front();
    checks++; if (!ok || rd !== e) begin errors++; $display("FAIL long_stb_data got %h want %h", rd, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [4];
    logic [31:0] e;
    int prev;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      data[i] = $urandom;
      wb_do(1'b1, 32'(16 + i), data[i], 4'hF);
      if (i > 0) begin
        checks++;
        if (ack_cyc - prev != WS + 3) begin errors++; $display("FAIL b2b_period got %0d want %0d", ack_cyc - prev, WS + 3); end
      end
      prev = ack_cyc;
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(data[i]);
    for (int i = 0; i < 4; i++) begin
      wb_do(1'b0, 32'(16 + i), 32'h0, 4'hF);
      e = exp_q.pop_front();
      checks++; if (!ok || rd !== e) begin errors++; $display("FAIL b2b_rd%0d got %h want %h", i, rd, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    bit got;
    wb_do(1'b1, 32'd9, 32'h00000077, 4'hF);
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = 32'd9; bus.wbs_dat_i = 32'h00000099; bus.wbs_sel_i = 4'hF;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o === 1'b1) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL rstmid_ack got none want ack"); end
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.wbs_ack_o !== 1'b0) begin errors++; $display("FAIL rstmid_ack_drop got %b want 0", bus.wbs_ack_o); end
    checks++; if (bus.wbs_int_o !== 1'b0) begin errors++; $display("FAIL rstmid_int got %b want 0", bus.wbs_int_o); end
    bus_idle();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    exp_q.push_back(32'h00000077);
    wb_do(1'b0, 32'd9, 32'h0, 4'hF);
    e = exp_q.pop_front();
    checks++; if (!ok || rd !== e) begin errors++; $display("FAIL rstmid_no_commit got %h want %h", rd, e); end
  endtask

  task automatic test_doorbell();
`ifdef WB_SCRATCH_INT_EN
    wb_do(1'b0, 32'd0, 32'h0, 4'hF);
    checks++; if (irq_after !== 1'b0) begin errors++; $display("FAIL bell_initial_clear got %b want 0", irq_after); end
    wb_do(1'b1, 32'd0, 32'h12345678, 4'h0);
    checks++; if (irq_ack !== 1'b0) begin errors++; $display("FAIL bell_during_ack got %b want 0", irq_ack); end
    checks++; if (irq_after !== 1'b1) begin errors++; $display("FAIL bell_set got %b want 1", irq_after); end
    wb_do(1'b0, 32'h00000100, 32'h0, 4'hF);
    checks++; if (irq_after !== 1'b1) begin errors++; $display("FAIL bell_oor_keeps got %b want 1", irq_after); end
    wb_do(1'b0, 32'd0, 32'h0, 4'hF);
    checks++; if (irq_after !== 1'b0) begin errors++; $display("FAIL bell_clear got %b want 0", irq_after); end
`else
    wb_do(1'b1, 32'd0, 32'h12345678, 4'hF);
    checks++; if (irq_ack !== 1'b0 || irq_after !== 1'b0) begin errors++; $display("FAIL bell_disabled_wr got %b/%b want 0/0", irq_ack, irq_after); end
    wb_do(1'b0, 32'd0, 32'h0, 4'hF);
    checks++; if (irq_after !== 1'b0) begin errors++; $display("FAIL bell_disabled_rd got %b want 0", irq_after); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    test_reset();
    test_write_read();
    test_byte_sel();
    test_out_of_range();
    test_abort();
    test_long_strobe();
    test_back_to_back();
    test_reset_mid();
    test_doorbell();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
